pipe_hazard_ctl: RTL and testbench
==================================

PIPE_HAZARD_CTL -- requirements
Module: pipe_hazard_ctl

Interface
REQ-001 Parameter MULT_CYCLES, default 4, legal range 2..16; total EX-stage occupancy of a multi-cycle multiply.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 id_rs1, id_rs2  input  [0:4] each  source register numbers of the instruction in ID.
REQ-005 id_uses_rs1, id_uses_rs2  input  1 each  the ID instruction reads that source.
REQ-006 ex_destReg  input  [0:4]  destination register of the instruction in EX.
REQ-007 ex_MemToReg  input  1  the EX instruction is a load.
REQ-008 ex_branch_taken  input  1  the EX instruction is a resolved taken branch or jump.
REQ-009 ex_mult  input  1  the EX instruction is a multi-cycle multiply.
REQ-010 pc_hold, if_id_hold, id_ex_hold  output  1 each  hold the PC / IF-ID / ID-EX register (drives the register ctl hold).
REQ-011 if_id_flush, id_ex_bubble, ex_mem_bubble  output  1 each  load a NOP into that pipeline register at the next edge.
REQ-012 mult_done  output  1  final EX cycle of a multiply; result valid this cycle.

Function
REQ-013 The block SHALL have states RUN and MULT_BUSY, plus a down-counter cnt of 4 bits.
REQ-014 Hazard outputs SHALL be combinational from state, cnt and the current-cycle inputs (zero-cycle latency).
REQ-015 Load-use: in RUN, if ex_MemToReg=1, ex_destReg!=0 and ex_destReg matches a used ID source, the block SHALL assert pc_hold, if_id_hold and id_ex_bubble for that cycle.
REQ-016 Register 0 SHALL never create a hazard.
REQ-017 Branch: in RUN, ex_branch_taken=1 SHALL assert if_id_flush and id_ex_bubble, and SHALL suppress any load-use stall in the same cycle.
REQ-018 Multiply entry: in RUN, ex_mult=1 with ex_branch_taken=0 SHALL assert pc_hold, if_id_hold, id_ex_hold and ex_mem_bubble, load cnt=MULT_CYCLES-2, and go to MULT_BUSY.
REQ-019 Multiply priority: on multiply entry, load-use is suppressed.
REQ-020 MULT_BUSY with cnt!=0 SHALL assert the same four signals as entry and decrement cnt.
REQ-021 MULT_BUSY with cnt==0 SHALL assert mult_done only, with no holds, and return to RUN.
REQ-022 Total hold cycles per multiply SHALL equal MULT_CYCLES-1.
REQ-023 In MULT_BUSY, ex_mult, ex_branch_taken and load-use inputs SHALL be ignored.
REQ-024 When MULT_CYCLES=2, the block SHALL enter MULT_BUSY with cnt=0, giving exactly one hold cycle.
REQ-025 Hold and bubble for the same register SHALL never be asserted together; if_id_flush and if_id_hold SHALL be mutually exclusive.

Reset
REQ-026 Asserting reset SHALL immediately set state=RUN and cnt=0, including mid-multiply.
REQ-027 While reset is high, all outputs SHALL be 0.
REQ-028 The first edge after reset release SHALL see normal RUN behaviour.

Configuration
REQ-029 With HAZARD_PERF_EN defined, the block SHALL add output stall_cycles [0:31].
REQ-030 stall_cycles SHALL count cycles with pc_hold=1, saturate at 32'hFFFFFFFF, and reset to 0.
REQ-031 Without HAZARD_PERF_EN, neither the port nor the counter SHALL exist.

Structure
REQ-032 The state encoding (RUN=1'b0, MULT_BUSY=1'b1), the register-number width 5 and the NOP encoding SHALL live in a shared pipeline package used by all pipeline registers.
REQ-033 The multiply counter SHALL be a sub-module mult_seq_cnt (load, decrement, zero flag); hazard decode stays in pipe_hazard_ctl.

Verification
REQ-034 The bench SHALL cover: ex_MemToReg=1, ex_destReg=5, id_rs2=5, id_uses_rs2=1 -> one cycle of pc_hold=if_id_hold=id_ex_bubble=1, then all 0.
REQ-035 The bench SHALL cover: the same load-use case with ex_destReg=0 -> no outputs asserted.
REQ-036 The bench SHALL cover: ex_branch_taken=1 together with a load-use match -> if_id_flush=id_ex_bubble=1, pc_hold=0.
REQ-037 The bench SHALL cover: MULT_CYCLES=4, ex_mult=1 -> holds asserted 3 consecutive cycles, mult_done on the 4th, then RUN.
REQ-038 The bench SHALL cover: reset pulsed during the 2nd multiply cycle -> outputs 0 immediately; after release, ex_mult=0 gives no holds.
REQ-039 The bench SHALL cover: HAZARD_PERF_EN defined, two multiplies (MULT_CYCLES=4) plus one load-use -> stall_cycles=7.

Source files
------------

// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared pipeline definitions: register index width, NOP encoding,
// hazard-control state encoding and the control-output bundle.
package pipe_hazard_ctl_pkg;

  localparam int REG_W = 5;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef logic [0:REG_W-1] reg_idx_t;

  typedef enum logic {
    RUN       = 1'b0,
    MULT_BUSY = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic id_ex_hold;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_bubble;
    logic mult_done;
  } hz_ctl_t;

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctl.
// stall_cycles only exists when HAZARD_PERF_EN is defined.
interface pipe_hazard_ctl_if;
  import pipe_hazard_ctl_pkg::*;

  reg_idx_t id_rs1;
  reg_idx_t id_rs2;
  logic     id_uses_rs1;
  logic     id_uses_rs2;
  reg_idx_t ex_destReg;
  logic     ex_MemToReg;
  logic     ex_branch_taken;
  logic     ex_mult;

  logic pc_hold;
  logic if_id_hold;
  logic id_ex_hold;
  logic if_id_flush;
  logic id_ex_bubble;
  logic ex_mem_bubble;
  logic mult_done;

`ifdef HAZARD_PERF_EN
  logic [0:31] stall_cycles;
`endif

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_destReg, ex_MemToReg, ex_branch_taken, ex_mult,
    input  pc_hold, if_id_hold, id_ex_hold,
    input  if_id_flush, id_ex_bubble, ex_mem_bubble, mult_done
`ifdef HAZARD_PERF_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_destReg, ex_MemToReg, ex_branch_taken, ex_mult,
    output pc_hold, if_id_hold, id_ex_hold,
    output if_id_flush, id_ex_bubble, ex_mem_bubble, mult_done
`ifdef HAZARD_PERF_EN
    , output stall_cycles
`endif
  );

endinterface

// File: rtl/pipe_hazard_ctl_mult_seq_cnt.sv
// Multiply sequencing down-counter: load, decrement, zero flag.
module mult_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, multi-cycle
// multiply hold. Define HAZARD_PERF_EN to add the stall_cycles counter.
module pipe_hazard_ctl
  import pipe_hazard_ctl_pkg::*;
#(
  parameter int MULT_CYCLES = 4
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctl_if.slave  hz
);

  localparam logic [3:0] CNT_INIT = 4'(MULT_CYCLES - 2);

  hz_state_e state_d, state_q;
  hz_ctl_t   ctl, ctl_o;
  logic      cnt_load, cnt_dec, cnt_zero;
  logic [3:0] cnt;
  logic      load_use;

  mult_seq_cnt #(.W(4)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (CNT_INIT),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    load_use = hz.ex_MemToReg && (hz.ex_destReg != '0) &&
      ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_destReg) ||
       (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_destReg));
  end

  always_comb begin
    ctl      = '0;
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.ex_branch_taken) begin
          ctl.if_id_flush  = 1'b1;
          ctl.id_ex_bubble = 1'b1;
        end else if (hz.ex_mult) begin
          ctl.pc_hold       = 1'b1;
          ctl.if_id_hold    = 1'b1;
          ctl.id_ex_hold    = 1'b1;
          ctl.ex_mem_bubble = 1'b1;
          cnt_load          = 1'b1;
          state_d           = MULT_BUSY;
        end else if (load_use) begin
          ctl.pc_hold      = 1'b1;
          ctl.if_id_hold   = 1'b1;
          ctl.id_ex_bubble = 1'b1;
        end
      end
      MULT_BUSY: begin
        if (!cnt_zero) begin
          ctl.pc_hold       = 1'b1;
          ctl.if_id_hold    = 1'b1;
          ctl.id_ex_hold    = 1'b1;
          ctl.ex_mem_bubble = 1'b1;
          cnt_dec           = 1'b1;
        end else begin
          ctl.mult_done = 1'b1;
          state_d       = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Outputs are forced quiet for as long as reset is held.
  assign ctl_o = reset ? '0 : ctl;

  assign hz.pc_hold       = ctl_o.pc_hold;
  assign hz.if_id_hold    = ctl_o.if_id_hold;
  assign hz.id_ex_hold    = ctl_o.id_ex_hold;
  assign hz.if_id_flush   = ctl_o.if_id_flush;
  assign hz.id_ex_bubble  = ctl_o.id_ex_bubble;
  assign hz.ex_mem_bubble = ctl_o.ex_mem_bubble;
  assign hz.mult_done     = ctl_o.mult_done;

`ifdef HAZARD_PERF_EN
  logic [0:31] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_q <= '0;
    else if (ctl_o.pc_hold && stall_q != '1)
      stall_q <= stall_q + 1'b1;
  end

  assign hz.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl: vector table plus multi-cycle sequences.
module tb_pipe_hazard_ctl;
  import pipe_hazard_ctl_pkg::*;

  localparam int MC = 4;

  // Expected-output order: pc, ifid_hold, idex_hold, flush, idex_bub, exmem_bub, done
  localparam logic [6:0] Z   = 7'b0000000;
  localparam logic [6:0] LU  = 7'b1100100;
  localparam logic [6:0] BR  = 7'b0001100;
  localparam logic [6:0] MH  = 7'b1110010;
  localparam logic [6:0] MD  = 7'b0000001;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] dest;
    logic       mem, br, mul;
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  pipe_hazard_ctl_if hz ();

  pipe_hazard_ctl #(.MULT_CYCLES(MC)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {hz.pc_hold, hz.if_id_hold, hz.id_ex_hold, hz.if_id_flush,
            hz.id_ex_bubble, hz.ex_mem_bubble, hz.mult_done};
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    hz.id_rs1          = v.rs1;
    hz.id_rs2          = v.rs2;
    hz.id_uses_rs1     = v.u1;
    hz.id_uses_rs2     = v.u2;
    hz.ex_destReg      = v.dest;
    hz.ex_MemToReg     = v.mem;
    hz.ex_branch_taken = v.br;
    hz.ex_mult         = v.mul;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [4:0] rs1, rs2, input logic u1, u2,
                              input logic [4:0] dest,
                              input logic mem, br, mul,
                              input logic [6:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.dest = dest;
    v.mem = mem; v.br = br; v.mul = mul; v.exp = exp;
    return v;
  endfunction

  task automatic run_mult(input string tag);
    drive(mk(5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, Z));
    for (int c = 0; c < MC - 1; c++) begin
      @(negedge clk);
      chk($sformatf("%s_hold%0d", tag, c), 32'(outs()), 32'(MH));
      next_cycle();
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(outs()), 32'(MD));
    next_cycle();
    drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Z));
  endtask

  vec_t tbl[10];
  vec_t nop, lu5;

  initial begin
    nop = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Z);
    lu5 = mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, LU);
    tbl[0] = nop;
    tbl[1] = lu5;
    tbl[2] = mk(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, Z);
    tbl[3] = mk(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, LU);
    tbl[4] = mk(5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, Z);
    tbl[5] = mk(5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, Z);
    tbl[6] = mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, BR);
    tbl[7] = mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, BR);
    tbl[8] = mk(5'd3, 5'd4, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, Z);
    tbl[9] = mk(5'd1, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, LU);

    // Reset with hazardous inputs applied: outputs must stay quiet.
    reset = 1'b0;
    drive(tbl[6]);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("reset_quiet", 32'(outs()), 32'(Z));
    next_cycle();
    reset = 1'b0;
    drive(nop);
    @(negedge clk);
    chk("post_reset_idle", 32'(outs()), 32'(Z));

    foreach (tbl[i]) begin
      next_cycle();
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // Load-use lasts one cycle, then the pipeline moves on.
    next_cycle();
    drive(lu5);
    @(negedge clk);
    chk("lu_stall", 32'(outs()), 32'(LU));
    next_cycle();
    drive(nop);
    @(negedge clk);
    chk("lu_release", 32'(outs()), 32'(Z));

    // Multiply with a load-use match present; a branch mid-multiply is ignored.
    next_cycle();
    drive(mk(5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, Z));
    @(negedge clk);
    chk("mul_entry", 32'(outs()), 32'(MH));
    next_cycle();
    hz.ex_branch_taken = 1'b1;
    @(negedge clk);
    chk("mul_busy1_br_ignored", 32'(outs()), 32'(MH));
    next_cycle();
    hz.ex_branch_taken = 1'b0;
    @(negedge clk);
    chk("mul_busy2", 32'(outs()), 32'(MH));
    next_cycle();
    @(negedge clk);
    chk("mul_done", 32'(outs()), 32'(MD));
    next_cycle();
    drive(lu5);
    @(negedge clk);
    chk("mul_back_to_run", 32'(outs()), 32'(LU));

    // Reset pulsed during the second multiply cycle.
    next_cycle();
    drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, Z));
    @(negedge clk);
    chk("rst_mul_entry", 32'(outs()), 32'(MH));
    next_cycle();
    @(negedge clk);
    chk("rst_mul_busy", 32'(outs()), 32'(MH));
    reset = 1'b1;
    #1;
    chk("rst_immediate", 32'(outs()), 32'(Z));
    next_cycle();
    reset = 1'b0;
    drive(nop);
    @(negedge clk);
    chk("rst_release_run", 32'(outs()), 32'(Z));
    next_cycle();
    @(negedge clk);
    chk("rst_release_run2", 32'(outs()), 32'(Z));

`ifdef HAZARD_PERF_EN
    next_cycle();
    reset = 1'b1;
    #1;
    chk("perf_reset", 32'(hz.stall_cycles), 32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    run_mult("perf_m1");
    next_cycle();
    run_mult("perf_m2");
    next_cycle();
    drive(lu5);
    @(negedge clk);
    chk("perf_lu", 32'(outs()), 32'(LU));
    next_cycle();
    drive(nop);
    @(negedge clk);
    chk("perf_count", 32'(hz.stall_cycles), 32'd7);
`endif

    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
